// File: rtl/mem_lsu.sv
// Memory stage between EX and WB: byte-serial loads and stores with little-endian assembly.
// Optional misalignment trap: define MEM_MISALIGN_CHK_EN.
`timescale 1ns/1ps

module mem_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   input  logic [4:0]        rd_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic              wreg_i,
   input  logic              mem_re_i,
   input  logic              mem_we_i,
   input  logic [2:0]        mem_op_i,
   input  logic [XLEN-1:0]   sdata_i,
   output logic [4:0]        rd_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic              wreg_o,
   output logic              wb_valid_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wr_o,
   output logic [7:0]        mem_dout_o,
   input  logic [7:0]        mem_din_i,
   output logic [1:0]        dbg_state_o
);

   // Handshake: an instruction is taken on a clock edge where in_valid_i is high
   // and stall_o is low; while stall_o is high EX must hold every input stable.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [3:0]        r_nbytes;
   logic              r_sign;
   logic [ADDR_W-1:0] r_base;
   logic [XLEN-1:0]   r_sdata;
   logic [XLEN-1:0]   r_acc;
   logic [4:0]        r_rd;
   logic              r_wreg;
   logic              r_misalign;

   function automatic logic [3:0] f_size(input logic [2:0] op);
      case (op)
         3'b000, 3'b100: f_size = 4'd1;
         3'b001, 3'b101: f_size = 4'd2;
         3'b011:         f_size = (XLEN == 64) ? 4'd8 : 4'd4;
         default:        f_size = 4'd4;
      endcase
   endfunction

   // Shift the valid bytes to the top, then shift back arithmetically or logically.
   function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                input logic [3:0]      nb,
                                                input logic            sgn);
      logic [6:0]      sh;
      logic [XLEN-1:0] t;
      sh = 7'(XLEN) - {nb, 3'b000};
      t  = d << sh;
      if (sgn)
         f_extend = XLEN'($signed(t) >>> sh);
      else
         f_extend = t >> sh;
   endfunction

   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_nbytes;
   logic              w_is_load;
   logic              w_is_store;
   logic              w_misalign;
   logic [3:0]        w_next_cnt;
   logic              w_more_beats;
   logic [ADDR_W-1:0] w_next_addr;
   logic [3:0]        w_samp_idx;
   logic              w_samp_en;
   logic              w_samp_last;
   logic [XLEN-1:0]   w_acc_next;
   logic [XLEN-1:0]   w_ld_result;
   logic [7:0]        w_next_byte;

   assign w_addr       = ADDR_W'(wdata_i);
   assign w_nbytes     = f_size(mem_op_i);
   assign w_is_load    = mem_re_i;
   assign w_is_store   = mem_we_i & ~mem_re_i;
   assign w_next_cnt   = r_cnt + 4'd1;
   assign w_more_beats = (w_next_cnt < r_nbytes);
   assign w_next_addr  = r_base + ADDR_W'(w_next_cnt);
   // r_cnt counts cycles since acceptance; byte k returns RD_LAT cycles after beat k.
   assign w_samp_idx   = r_cnt - 4'(RD_LAT);
   assign w_samp_en    = (r_cnt >= 4'(RD_LAT));
   assign w_samp_last  = w_samp_en && (w_samp_idx == (r_nbytes - 4'd1));
   assign w_ld_result  = f_extend(w_acc_next, r_nbytes, r_sign);
   assign w_next_byte  = 8'(r_sdata >> {w_next_cnt[2:0], 3'b000});

   always_comb begin
      w_acc_next = r_acc;
      for (int b = 0; b < XLEN / 8; b++) begin
         if (w_samp_en && (w_samp_idx == 4'(b)))
            w_acc_next[8*b +: 8] = mem_din_i;
      end
   end

`ifdef MEM_MISALIGN_CHK_EN
   always_comb begin
      case (mem_op_i)
         3'b001, 3'b101: w_misalign = w_addr[0];
         3'b010, 3'b110: w_misalign = |w_addr[1:0];
         3'b011:         w_misalign = |w_addr[2:0];
         default:        w_misalign = 1'b0;
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_nbytes   <= '0;
         r_sign     <= 1'b0;
         r_base     <= '0;
         r_sdata    <= '0;
         r_acc      <= '0;
         r_rd       <= '0;
         r_wreg     <= 1'b0;
         r_misalign <= 1'b0;
         rd_o       <= '0;
         wdata_o    <= '0;
         wreg_o     <= 1'b0;
         wb_valid_o <= 1'b0;
         mem_addr_o <= '0;
         mem_wr_o   <= 1'b0;
         mem_dout_o <= '0;
      end else begin
         wb_valid_o <= 1'b0;
         wreg_o     <= 1'b0;
         mem_wr_o   <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  if (!(w_is_load || w_is_store)) begin
                     rd_o       <= rd_i;
                     wdata_o    <= wdata_i;
                     wreg_o     <= wreg_i;
                     wb_valid_o <= 1'b1;
                  end else if (w_misalign) begin
                     wb_valid_o <= 1'b1;
                     r_misalign <= 1'b1;
                  end else begin
                     r_base     <= w_addr;
                     r_nbytes   <= w_nbytes;
                     r_sign     <= ~mem_op_i[2];
                     r_rd       <= rd_i;
                     r_wreg     <= wreg_i;
                     r_sdata    <= sdata_i;
                     r_acc      <= '0;
                     r_cnt      <= '0;
                     mem_addr_o <= w_addr;
                     if (w_is_load) begin
                        r_state <= S_LOAD;
                     end else begin
                        r_state    <= S_STORE;
                        mem_wr_o   <= 1'b1;
                        mem_dout_o <= sdata_i[7:0];
                     end
                  end
               end
            end
            S_LOAD: begin
               r_cnt <= w_next_cnt;
               r_acc <= w_acc_next;
               if (w_more_beats)
                  mem_addr_o <= w_next_addr;
               if (w_samp_last) begin
                  wdata_o    <= w_ld_result;
                  rd_o       <= r_rd;
                  wreg_o     <= r_wreg;
                  wb_valid_o <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            S_STORE: begin
               if (w_more_beats) begin
                  mem_addr_o <= w_next_addr;
                  mem_dout_o <= w_next_byte;
                  mem_wr_o   <= 1'b1;
                  r_cnt      <= w_next_cnt;
               end else begin
                  wb_valid_o <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_o     = (r_state != S_IDLE);
   assign misalign_o  = r_misalign;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a vector table on an RD_LAT=1 instance plus
// hand-written reset, store, wrap, misalignment and RD_LAT=3 sequences.
`timescale 1ns/1ps

module tb_mem_lsu;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared instruction inputs; each instance has its own valid
   logic [4:0]  rd_i;
   logic [31:0] wdata_i;
   logic [31:0] sdata_i;
   logic        wreg_i;
   logic        mem_re_i;
   logic        mem_we_i;
   logic [2:0]  mem_op_i;
   logic        v1;
   logic        v3;

   logic [4:0]  rd1, rd3;
   logic [31:0] wdata1, wdata3, addr1, addr3;
   logic        wreg1, wreg3, wb1, wb3, stall1, stall3, mis1, mis3, wr1, wr3;
   logic [7:0]  dout1, dout3, din1, din3;
   logic [1:0]  st1, st3;

   mem_lsu #(.XLEN(32), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid_i(v1), .rd_i(rd_i), .wdata_i(wdata_i),
      .wreg_i(wreg_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
      .sdata_i(sdata_i), .rd_o(rd1), .wdata_o(wdata1), .wreg_o(wreg1),
      .wb_valid_o(wb1), .stall_o(stall1), .misalign_o(mis1), .mem_addr_o(addr1),
      .mem_wr_o(wr1), .mem_dout_o(dout1), .mem_din_i(din1), .dbg_state_o(st1)
   );

   mem_lsu #(.XLEN(32), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid_i(v3), .rd_i(rd_i), .wdata_i(wdata_i),
      .wreg_i(wreg_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
      .sdata_i(sdata_i), .rd_o(rd3), .wdata_o(wdata3), .wreg_o(wreg3),
      .wb_valid_o(wb3), .stall_o(stall3), .misalign_o(mis3), .mem_addr_o(addr3),
      .mem_wr_o(wr3), .mem_dout_o(dout3), .mem_din_i(din3), .dbg_state_o(st3)
   );

   // ---------------- RAM models (address low 10 bits, pipelined read) ----------------
   logic [7:0] mem1 [0:1023];
   logic [7:0] mem3 [0:1023];
   logic [7:0] pipe1;
   logic [7:0] pipe3 [0:2];

   function automatic logic [7:0] f_init(input int a);
      case (a)
         'h100: f_init = 8'h80;  'h101: f_init = 8'h7F;
         'h102: f_init = 8'h34;  'h103: f_init = 8'h12;
         'h104: f_init = 8'h00;  'h105: f_init = 8'h90;
         'h106: f_init = 8'h01;  'h107: f_init = 8'hF0;
         'h3FE: f_init = 8'hAA;  'h3FF: f_init = 8'hBB;
         'h000: f_init = 8'hCC;  'h001: f_init = 8'hDD;
         default: f_init = 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) begin
            mem1[i] <= f_init(i);
            mem3[i] <= f_init(i);
         end
      end else begin
         if (wr1) mem1[addr1[9:0]] <= dout1;
         if (wr3) mem3[addr3[9:0]] <= dout3;
      end
      pipe1    <= mem1[addr1[9:0]];
      pipe3[0] <= mem3[addr3[9:0]];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign din1 = pipe1;
   assign din3 = pipe3[2];

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [39:0] exp_q[$];
   logic [39:0] obs_q[$];
   logic [31:0] addr_log [0:31];

   always @(negedge clk) begin
      if (wr1) obs_q.push_back({addr1, dout1});
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // kind: 0 non-memory, 1 load, 2 store, 3 load with both strobes high
   task automatic run1(input logic [1:0] kind, input logic [2:0] op, input logic [4:0] rd,
                       input logic wreg, input logic [31:0] wd, input logic [31:0] sd,
                       output int lat, output int busy);
      @(negedge clk);
      rd_i     = rd;
      wdata_i  = wd;
      sdata_i  = sd;
      wreg_i   = wreg;
      mem_op_i = op;
      mem_re_i = (kind == 2'd1) || (kind == 2'd3);
      mem_we_i = (kind == 2'd2) || (kind == 2'd3);
      v1       = 1'b1;
      lat      = -1;
      busy     = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         v1 = 1'b0;
         addr_log[c] = addr1;
         if (stall1) busy++;
         if (wb1) begin
            lat = c;
            break;
         end
      end
   endtask

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic        wreg;
      logic [31:0] wd;
      logic [31:0] sd;
      logic [31:0] exp_data;
      logic        exp_wreg;
      int          lat;
   } vec_t;

   localparam int NV = 15;
   vec_t vt [0:NV-1];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy;
      int cnt;
      logic [39:0] e;
      logic [39:0] o;

      vt[0]  = '{2'd0, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, 0};
      vt[1]  = '{2'd1, 3'b001, 5'd6,  1'b1, 32'h0000_0100, 32'h0, 32'h0000_7F80, 1'b1, 3};
      vt[2]  = '{2'd1, 3'b000, 5'd7,  1'b1, 32'h0000_0100, 32'h0, 32'hFFFF_FF80, 1'b1, 2};
      vt[3]  = '{2'd1, 3'b100, 5'd8,  1'b1, 32'h0000_0100, 32'h0, 32'h0000_0080, 1'b1, 2};
      vt[4]  = '{2'd1, 3'b010, 5'd9,  1'b1, 32'h0000_0100, 32'h0, 32'h1234_7F80, 1'b1, 5};
      vt[5]  = '{2'd1, 3'b001, 5'd10, 1'b1, 32'h0000_0104, 32'h0, 32'hFFFF_9000, 1'b1, 3};
      vt[6]  = '{2'd1, 3'b101, 5'd11, 1'b1, 32'h0000_0104, 32'h0, 32'h0000_9000, 1'b1, 3};
      vt[7]  = '{2'd1, 3'b110, 5'd12, 1'b1, 32'h0000_0104, 32'h0, 32'hF001_9000, 1'b1, 5};
      vt[8]  = '{2'd1, 3'b011, 5'd13, 1'b1, 32'h0000_0100, 32'h0, 32'h1234_7F80, 1'b1, 5};
      vt[9]  = '{2'd3, 3'b111, 5'd14, 1'b1, 32'h0000_0104, 32'h0, 32'hF001_9000, 1'b1, 5};
      vt[10] = '{2'd0, 3'b000, 5'd31, 1'b0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b0, 0};
      vt[11] = '{2'd2, 3'b000, 5'd0,  1'b1, 32'h0000_0300, 32'h1122_3355, 32'h0, 1'b0, 1};
      vt[12] = '{2'd2, 3'b001, 5'd0,  1'b1, 32'h0000_0302, 32'hAAAA_6677, 32'h0, 1'b0, 2};
      vt[13] = '{2'd1, 3'b010, 5'd15, 1'b1, 32'h0000_0300, 32'h0, 32'h6677_0055, 1'b1, 5};
      vt[14] = '{2'd1, 3'b000, 5'd16, 1'b0, 32'h0000_0107, 32'h0, 32'hFFFF_FFF0, 1'b0, 2};

      rd_i = '0; wdata_i = '0; sdata_i = '0; wreg_i = 1'b0;
      mem_re_i = 1'b0; mem_we_i = 1'b0; mem_op_i = '0; v1 = 1'b0; v3 = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_wb",    64'(wb1),    64'h0);
      chk("rst_stall", 64'(stall1), 64'h0);
      chk("rst_addr",  64'(addr1),  64'h0);
      chk("rst_state", 64'(st1),    64'h0);
      chk("rst_stall3", 64'(stall3), 64'h0);
      rst = 1'b0;

      // reset with an LW in flight
      @(negedge clk);
      rd_i = 5'd3; wdata_i = 32'h100; wreg_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0;
      mem_op_i = 3'b010; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(stall1), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_stall", 64'(stall1), 64'h0);
      chk("midrst_addr",  64'(addr1),  64'h0);
      chk("midrst_wreg",  64'(wreg1),  64'h0);
      chk("midrst_wdata", 64'(wdata1), 64'h0);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (wb1) cnt++;
         @(negedge clk);
      end
      chk("midrst_no_wb", 64'(cnt), 64'h0);

      // table-driven vectors on the RD_LAT=1 instance
      for (int i = 0; i < NV; i++) begin
         run1(vt[i].kind, vt[i].op, vt[i].rd, vt[i].wreg, vt[i].wd, vt[i].sd, lat, busy);
         chk($sformatf("v%0d_lat", i),  64'(lat),   64'(vt[i].lat));
         chk($sformatf("v%0d_busy", i), 64'(busy),  64'(vt[i].lat));
         chk($sformatf("v%0d_wreg", i), 64'(wreg1), 64'(vt[i].exp_wreg));
         if (vt[i].kind != 2'd2) begin
            chk($sformatf("v%0d_rd", i),    64'(rd1),    64'(vt[i].rd));
            chk($sformatf("v%0d_wdata", i), 64'(wdata1), 64'(vt[i].exp_data));
         end
      end

      // SW 0xDEADBEEF at 0x200 with beat-level scoreboard
      obs_q.delete();
      exp_q.delete();
      exp_q.push_back({32'h200, 8'hEF});
      exp_q.push_back({32'h201, 8'hBE});
      exp_q.push_back({32'h202, 8'hAD});
      exp_q.push_back({32'h203, 8'hDE});
      run1(2'd2, 3'b010, 5'd1, 1'b1, 32'h200, 32'hDEAD_BEEF, lat, busy);
      chk("sw_lat",    64'(lat),   64'd4);
      chk("sw_wreg",   64'(wreg1), 64'h0);
      chk("sw_wr_off", 64'(wr1),   64'h0);
      chk("sw_nbeats", 64'(obs_q.size()), 64'd4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 40'hFF_FFFF_FFFF;
         chk("sw_beat", 64'(o), 64'(e));
      end
      run1(2'd1, 3'b010, 5'd2, 1'b1, 32'h200, 32'h0, lat, busy);
      chk("sw_readback", 64'(wdata1), 64'hDEAD_BEEF);

`ifndef MEM_MISALIGN_CHK_EN
      // LW wrapping past the top of the address space
      run1(2'd1, 3'b010, 5'd20, 1'b1, 32'hFFFF_FFFE, 32'h0, lat, busy);
      chk("wrap_lat",  64'(lat),    64'd5);
      chk("wrap_data", 64'(wdata1), 64'hDDCC_BBAA);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] ea;
         ea = 32'hFFFF_FFFE + 32'(k);
         chk($sformatf("wrap_addr%0d", k), 64'(addr_log[k]), 64'(ea));
      end
      // misaligned accesses run byte-by-byte without the check
      run1(2'd1, 3'b010, 5'd21, 1'b1, 32'h102, 32'h0, lat, busy);
      chk("mis_lw_lat",  64'(lat),    64'd5);
      chk("mis_lw_data", 64'(wdata1), 64'h9000_1234);
      chk("mis_lw_flag", 64'(mis1),   64'h0);
      obs_q.delete();
      run1(2'd2, 3'b001, 5'd0, 1'b0, 32'h301, 32'h0000_4321, lat, busy);
      chk("mis_sh_lat",    64'(lat), 64'd2);
      chk("mis_sh_nbeats", 64'(obs_q.size()), 64'd2);
`else
      obs_q.delete();
      run1(2'd1, 3'b010, 5'd21, 1'b1, 32'h102, 32'h0, lat, busy);
      chk("mis_lw_lat",  64'(lat),   64'd0);
      chk("mis_lw_busy", 64'(busy),  64'd0);
      chk("mis_lw_wreg", 64'(wreg1), 64'h0);
      chk("mis_lw_flag", 64'(mis1),  64'h1);
      @(negedge clk);
      chk("mis_lw_pulse", 64'(mis1), 64'h0);
      run1(2'd2, 3'b001, 5'd0, 1'b0, 32'h301, 32'h0000_4321, lat, busy);
      chk("mis_sh_lat",    64'(lat),  64'd0);
      chk("mis_sh_flag",   64'(mis1), 64'h1);
      chk("mis_sh_nbeats", 64'(obs_q.size()), 64'd0);
`endif

      // RD_LAT=3: LW held by upstream, then ADD presented as the stall drops
      @(negedge clk);
      rd_i = 5'd22; wdata_i = 32'h100; sdata_i = '0; wreg_i = 1'b1;
      mem_re_i = 1'b1; mem_we_i = 1'b0; mem_op_i = 3'b010; v3 = 1'b1;
      busy = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 0) chk("rl3_state_load", 64'(st3), 64'd1);
         if (!stall3) break;
         busy++;
      end
      chk("rl3_busy",  64'(busy),   64'd7);
      chk("rl3_wb",    64'(wb3),    64'h1);
      chk("rl3_rd",    64'(rd3),    64'd22);
      chk("rl3_wdata", 64'(wdata3), 64'h1234_7F80);
      rd_i = 5'd23; wdata_i = 32'h5A5A; wreg_i = 1'b1; mem_re_i = 1'b0; mem_we_i = 1'b0;
      @(negedge clk);
      v3 = 1'b0;
      chk("rl3_add_wb",    64'(wb3),    64'h1);
      chk("rl3_add_rd",    64'(rd3),    64'd23);
      chk("rl3_add_wdata", 64'(wdata3), 64'h5A5A);
      chk("rl3_add_stall", 64'(stall3), 64'h0);
      @(negedge clk);
      chk("rl3_wb_pulse", 64'(wb3), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
